load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/riscv_pkg.sv | 83 ++++++++
 rtl/load_extend.sv | 36 +++
 rtl/load_store_unit.sv | 147 ++++++++++++++
 tb/tb_load_store_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the load/store unit:
//   - Funct3 encodings for byte/half/word loads and stores
//   - fault_cause codes reported on a faulting memory operation
//   - FSM state enum of the load/store unit
//   - helper functions that classify an op and shape store lanes
// ---------------------------------------------------------------------------
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;   // LB / SB
   localparam logic [2:0] F3_H  = 3'b001;   // LH / SH
   localparam logic [2:0] F3_W  = 3'b010;   // LW / SW
   localparam logic [2:0] F3_BU = 3'b100;   // LBU
   localparam logic [2:0] F3_HU = 3'b101;   // LHU

   typedef enum logic [1:0] {
      FC_NONE       = 2'b00,
      FC_MISALIGNED = 2'b01,
      FC_ILLEGAL    = 2'b10,
      FC_RW_BOTH    = 2'b11
   } fault_cause_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_WAIT = 2'b10,
      ST_DONE = 2'b11
   } lsu_state_t;

   // Classify an op. Priority: both directions set, then illegal Funct3,
   // then misalignment.
   function automatic fault_cause_t fault_check(
      input logic       is_read,
      input logic       is_write,
      input logic [2:0] f3,
      input logic [1:0] addr_lo
   );
      logic w_illegal;
      logic w_misaligned;
      if (is_write) begin
         w_illegal = !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W));
      end else begin
         w_illegal = !((f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                       (f3 == F3_BU) || (f3 == F3_HU));
      end
      w_misaligned = (((f3 == F3_H) || (f3 == F3_HU)) && addr_lo[0]) ||
                     ((f3 == F3_W) && (addr_lo != 2'b00));
      if (is_read && is_write) begin
         return FC_RW_BOTH;
      end else if (w_illegal) begin
         return FC_ILLEGAL;
      end else if (w_misaligned) begin
         return FC_MISALIGNED;
      end else begin
         return FC_NONE;
      end
   endfunction

   function automatic logic [3:0] store_be(
      input logic [2:0] f3,
      input logic [1:0] addr_lo
   );
      case (f3)
         F3_B:    return 4'b0001 << addr_lo;
         F3_H:    return 4'b0011 << addr_lo;
         default: return 4'b1111;
      endcase
   endfunction

   // Lanes are replicated so the byte-enable alone selects the target bytes.
   function automatic logic [31:0] store_wdata(
      input logic [2:0]  f3,
      input logic [31:0] data
   );
      case (f3)
         F3_B:    return {4{data[7:0]}};
         F3_H:    return {2{data[15:0]}};
         default: return data;
      endcase
   endfunction

endpackage

// File: rtl/load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
// Combinational extraction of the addressed byte/half/word from a 32-bit
// read word, followed by sign or zero extension.
// Ports:
//   rdata  [31:0] in  : aligned word returned by memory
//   offset [1:0]  in  : byte offset of the access within the word
//   Funct3 [2:0]  in  : load encoding (LB/LH/LW/LBU/LHU)
//   result [31:0] out : extended load value
// ---------------------------------------------------------------------------
module load_extend
   import riscv_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  Funct3,
   output logic [31:0] result
);

   logic [31:0] w_shifted;

   // Move the addressed byte/half down to bit 0.
   assign w_shifted = rdata >> {offset, 3'b000};

   always_comb begin
      result = w_shifted;
      case (Funct3)
         F3_B:    result = {{24{w_shifted[7]}}, w_shifted[7:0]};
         F3_H:    result = {{16{w_shifted[15]}}, w_shifted[15:0]};
         F3_BU:   result = {24'h000000, w_shifted[7:0]};
         F3_HU:   result = {16'h0000, w_shifted[15:0]};
         default: result = w_shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Accepts one EX-stage memory op at a time, checks it for faults, runs a
// req/gnt + rvalid handshake on the data-memory port and returns extended
// load data to writeback.
// Ports:
//   clk, reset                      : clock, asynchronous active-high reset
//   mem_op_valid, MemRead, MemWrite,
//   Funct3, ALUResult, StoreData, Rd : op presented by EX (held while stall)
//   stall                            : upstream must hold the op inputs
//   dmem_req/we/addr/be/wdata        : memory request channel
//   dmem_gnt, dmem_rvalid, dmem_rdata: memory response channel
//   load_valid, LoadResult, load_rd  : writeback of a completed load
//   mem_fault, fault_cause           : one-cycle fault pulse with its cause
// ---------------------------------------------------------------------------
module load_store_unit
   import riscv_pkg::*;
#(
   parameter int DATA_WIDTH = 32
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_op_valid,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [2:0]            Funct3,
   input  logic [DATA_WIDTH-1:0] ALUResult,
   input  logic [DATA_WIDTH-1:0] StoreData,
   input  logic [4:0]            Rd,
   output logic                  stall,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [DATA_WIDTH-1:0] dmem_addr,
   output logic [3:0]            dmem_be,
   output logic [DATA_WIDTH-1:0] dmem_wdata,
   input  logic                  dmem_gnt,
   input  logic                  dmem_rvalid,
   input  logic [DATA_WIDTH-1:0] dmem_rdata,
   output logic                  load_valid,
   output logic [DATA_WIDTH-1:0] LoadResult,
   output logic [4:0]            load_rd,
   output logic                  mem_fault,
   output logic [1:0]            fault_cause
);

   lsu_state_t            r_state;
   logic [DATA_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [3:0]            r_be;
   logic [2:0]            r_funct3;
   logic [4:0]            r_rd;
   logic                  r_is_store;
   logic [DATA_WIDTH-1:0] r_load_result;
   logic                  r_load_valid;
   logic                  r_fault;
   fault_cause_t          r_cause;

   logic                  w_accept;
   fault_cause_t          w_cause;
   logic [DATA_WIDTH-1:0] w_ext;

   assign w_accept = mem_op_valid && (MemRead || MemWrite);
   assign w_cause  = fault_check(MemRead, MemWrite, Funct3, ALUResult[1:0]);

   load_extend u_load_extend (
      .rdata  (dmem_rdata),
      .offset (r_addr[1:0]),
      .Funct3 (r_funct3),
      .result (w_ext)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_addr        <= '0;
         r_wdata       <= '0;
         r_be          <= '0;
         r_funct3      <= '0;
         r_rd          <= '0;
         r_is_store    <= 1'b0;
         r_load_result <= '0;
         r_load_valid  <= 1'b0;
         r_fault       <= 1'b0;
         r_cause       <= FC_NONE;
      end else begin
         // Completion pulses are only ever set on entry to DONE, so clearing
         // them by default makes them last exactly the DONE cycle.
         r_load_valid <= 1'b0;
         r_fault      <= 1'b0;
         r_cause      <= FC_NONE;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_addr     <= ALUResult;
                  r_funct3   <= Funct3;
                  r_rd       <= Rd;
                  r_is_store <= MemWrite;
                  r_be       <= MemWrite ? store_be(Funct3, ALUResult[1:0]) : 4'b1111;
                  r_wdata    <= MemWrite ? store_wdata(Funct3, StoreData) : '0;
                  if (w_cause != FC_NONE) begin
                     r_fault <= 1'b1;
                     r_cause <= w_cause;
                     r_state <= ST_DONE;
                  end else begin
                     r_state <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (dmem_gnt) begin
                  r_state <= r_is_store ? ST_DONE : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (dmem_rvalid) begin
                  r_load_result <= w_ext;
                  r_load_valid  <= 1'b1;
                  r_state       <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // The accept term is gated by reset so stall stays low while reset is
   // held even if EX keeps presenting an op.
   assign stall = ((r_state == ST_IDLE) && w_accept && !reset) ||
                  (r_state == ST_REQ) || (r_state == ST_WAIT);

   assign dmem_req    = (r_state == ST_REQ);
   assign dmem_we     = (r_state == ST_REQ) && r_is_store;
   assign dmem_addr   = {r_addr[DATA_WIDTH-1:2], 2'b00};
   assign dmem_be     = r_be;
   assign dmem_wdata  = r_wdata;
   assign load_valid  = r_load_valid;
   assign LoadResult  = r_load_result;
   assign load_rd     = r_rd;
   assign mem_fault   = r_fault;
   assign fault_cause = r_cause;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a scoreboard of expected op results.
module tb_load_store_unit;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        mem_op_valid = 1'b0;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic [2:0]  Funct3 = 3'b000;
   logic [31:0] ALUResult = '0;
   logic [31:0] StoreData = '0;
   logic [4:0]  Rd = '0;
   logic        stall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt = 1'b0;
   logic        dmem_rvalid = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic        load_valid;
   logic [31:0] LoadResult;
   logic [4:0]  load_rd;
   logic        mem_fault;
   logic [1:0]  fault_cause;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          is_load;
      bit          has_req;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] result;
      logic [4:0]  rd;
      logic        fault;
      logic [1:0]  cause;
   } exp_t;

   exp_t sb_q[$];

   load_store_unit #(.DATA_WIDTH(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .mem_op_valid (mem_op_valid),
      .MemRead      (MemRead),
      .MemWrite     (MemWrite),
      .Funct3       (Funct3),
      .ALUResult    (ALUResult),
      .StoreData    (StoreData),
      .Rd           (Rd),
      .stall        (stall),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .dmem_addr    (dmem_addr),
      .dmem_be      (dmem_be),
      .dmem_wdata   (dmem_wdata),
      .dmem_gnt     (dmem_gnt),
      .dmem_rvalid  (dmem_rvalid),
      .dmem_rdata   (dmem_rdata),
      .load_valid   (load_valid),
      .LoadResult   (LoadResult),
      .load_rd      (load_rd),
      .mem_fault    (mem_fault),
      .fault_cause  (fault_cause)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_op(input bit is_load, input bit has_req, input logic we,
                            input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata, input logic [31:0] result,
                            input logic [4:0] rd, input logic fault, input logic [1:0] cause);
      exp_t e;
      e.is_load = is_load; e.has_req = has_req; e.we = we; e.addr = addr; e.be = be;
      e.wdata = wdata; e.result = result; e.rd = rd; e.fault = fault; e.cause = cause;
      sb_q.push_back(e);
   endtask

   // Drives one op, plays the memory side, and compares against the oldest
   // scoreboard entry. gnt_delay = request cycles without grant; rv_delay =
   // WAIT cycles before rvalid.
   task automatic run_op(input string name, input logic rd_en, input logic wr_en,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] rd,
                         input int gnt_delay, input logic [31:0] rdata, input int rv_delay);
      exp_t e;
      bit   done = 0;
      bit   req_seen = 0;
      bit   granted = 0;
      int   req_cyc = 0;
      int   wait_cyc = 0;
      int   done_cyc = 0;
      @(negedge clk);
      mem_op_valid = 1'b1; MemRead = rd_en; MemWrite = wr_en; Funct3 = f3;
      ALUResult = addr; StoreData = data; Rd = rd;
      #1 chk({name, ":stall_accept"}, 32'(stall), 32'd1);
      if (sb_q.size() == 0) begin
         chk({name, ":sb_entry"}, 32'(sb_q.size()), 32'd1);
         return;
      end
      e = sb_q.pop_front();
      for (int cyc = 0; cyc < 50 && !done; cyc++) begin
         @(negedge clk);
         dmem_gnt = 1'b0;
         dmem_rvalid = 1'b0;
         if (!stall) begin
            done = 1;
            done_cyc = cyc;
         end else if (dmem_req) begin
            req_seen = 1;
            chk({name, ":addr"}, dmem_addr, e.addr);
            chk({name, ":be"}, 32'(dmem_be), 32'(e.be));
            chk({name, ":we"}, 32'(dmem_we), 32'(e.we));
            if (!e.is_load) chk({name, ":wdata"}, dmem_wdata, e.wdata);
            req_cyc++;
            if (req_cyc > gnt_delay) begin
               dmem_gnt = 1'b1;
               granted = 1;
            end
         end else if (granted) begin
            wait_cyc++;
            if (wait_cyc > rv_delay) begin
               dmem_rvalid = 1'b1;
               dmem_rdata = rdata;
            end
         end
      end
      mem_op_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      chk({name, ":completed"}, 32'(done), 32'd1);
      chk({name, ":req_issued"}, 32'(req_seen), 32'(e.has_req));
      chk({name, ":done_req_low"}, 32'(dmem_req), 32'd0);
      chk({name, ":load_valid"}, 32'(load_valid), 32'(e.is_load && !e.fault));
      chk({name, ":mem_fault"}, 32'(mem_fault), 32'(e.fault));
      chk({name, ":fault_cause"}, 32'(fault_cause), 32'(e.cause));
      if (e.is_load && !e.fault) begin
         chk({name, ":LoadResult"}, LoadResult, e.result);
         chk({name, ":load_rd"}, 32'(load_rd), 32'(e.rd));
      end
      if (e.fault) chk({name, ":fault_latency"}, 32'(done_cyc), 32'd0);
      @(negedge clk);
      chk({name, ":lv_pulse_end"}, 32'(load_valid), 32'd0);
      chk({name, ":fault_pulse_end"}, 32'(mem_fault), 32'd0);
      chk({name, ":cause_clear"}, 32'(fault_cause), 32'd0);
      chk({name, ":idle_stall"}, 32'(stall), 32'd0);
      $display("op %s done_cyc=%0d req=%0d lv=%0d fault=%0d cause=%b result=%h",
               name, done_cyc, req_seen, e.is_load && !e.fault, e.fault, e.cause, e.result);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, with an op presented so the stall gating is exercised.
      mem_op_valid = 1'b1; MemRead = 1'b1; ALUResult = 32'h0000_0104;
      @(negedge clk);
      chk("rst:stall", 32'(stall), 32'd0);
      chk("rst:req", 32'(dmem_req), 32'd0);
      chk("rst:we", 32'(dmem_we), 32'd0);
      chk("rst:lv", 32'(load_valid), 32'd0);
      chk("rst:fault", 32'(mem_fault), 32'd0);
      chk("rst:addr", dmem_addr, 32'd0);
      chk("rst:be", 32'(dmem_be), 32'd0);
      chk("rst:wdata", dmem_wdata, 32'd0);
      chk("rst:result", LoadResult, 32'd0);
      chk("rst:rd", 32'(load_rd), 32'd0);
      chk("rst:cause", 32'(fault_cause), 32'd0);
      mem_op_valid = 1'b0; MemRead = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      // Responses outside REQ/WAIT must be ignored.
      dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
      repeat (2) begin
         @(negedge clk);
         chk("idle_ignore:stall", 32'(stall), 32'd0);
         chk("idle_ignore:lv", 32'(load_valid), 32'd0);
         chk("idle_ignore:req", 32'(dmem_req), 32'd0);
      end
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;

      expect_op(0, 1, 1, 32'h100, 4'b1111, 32'hDEADBEEF, '0, '0, 0, 2'b00);
      run_op("SW_100", 0, 1, F3_W, 32'h100, 32'hDEADBEEF, 5'd1, 2, '0, 0);
      expect_op(1, 1, 0, 32'h100, 4'b1111, '0, 32'hFFFFFF80, 5'd5, 0, 2'b00);
      run_op("LB_103", 1, 0, F3_B, 32'h103, '0, 5'd5, 1, 32'h80FF_0000, 1);
      expect_op(1, 1, 0, 32'h100, 4'b1111, '0, 32'h00000080, 5'd6, 0, 2'b00);
      run_op("LBU_103", 1, 0, F3_BU, 32'h103, '0, 5'd6, 0, 32'h80FF_0000, 0);
      expect_op(0, 1, 1, 32'h100, 4'b1100, 32'hABCDABCD, '0, '0, 0, 2'b00);
      run_op("SH_102", 0, 1, F3_H, 32'h102, 32'h1234ABCD, 5'd2, 0, '0, 0);
      expect_op(1, 0, 0, '0, '0, '0, '0, '0, 1, 2'b01);
      run_op("LW_101", 1, 0, F3_W, 32'h101, '0, 5'd3, 0, '0, 0);
      expect_op(0, 0, 0, '0, '0, '0, '0, '0, 1, 2'b11);
      run_op("RW_both", 1, 1, 3'b011, 32'h0, 32'h5, 5'd4, 0, '0, 0);
      expect_op(0, 1, 1, 32'h200, 4'b0010, 32'hA5A5A5A5, '0, '0, 0, 2'b00);
      run_op("SB_201", 0, 1, F3_B, 32'h201, 32'h123456A5, 5'd7, 1, '0, 0);
      expect_op(1, 1, 0, 32'h200, 4'b1111, '0, 32'hFFFF8001, 5'd9, 0, 2'b00);
      run_op("LH_202", 1, 0, F3_H, 32'h202, '0, 5'd9, 0, 32'h8001_1234, 2);
      expect_op(1, 1, 0, 32'h200, 4'b1111, '0, 32'h00008001, 5'd10, 0, 2'b00);
      run_op("LHU_202", 1, 0, F3_HU, 32'h202, '0, 5'd10, 1, 32'h8001_1234, 0);
      expect_op(1, 1, 0, 32'h204, 4'b1111, '0, 32'hCAFEF00D, 5'd31, 0, 2'b00);
      run_op("LW_204", 1, 0, F3_W, 32'h204, '0, 5'd31, 0, 32'hCAFE_F00D, 3);
      expect_op(1, 1, 0, 32'h100, 4'b1111, '0, 32'h0000007F, 5'd11, 0, 2'b00);
      run_op("LB_100", 1, 0, F3_B, 32'h100, '0, 5'd11, 0, 32'h0000_007F, 0);
      expect_op(1, 0, 0, '0, '0, '0, '0, '0, 1, 2'b10);
      run_op("ILL_LD_110", 1, 0, 3'b110, 32'h0, '0, 5'd12, 0, '0, 0);
      expect_op(0, 0, 0, '0, '0, '0, '0, '0, 1, 2'b10);
      run_op("ILL_ST_100", 0, 1, 3'b100, 32'h3, 32'h1, 5'd13, 0, '0, 0);
      expect_op(0, 0, 0, '0, '0, '0, '0, '0, 1, 2'b01);
      run_op("SH_101", 0, 1, F3_H, 32'h101, 32'h1, 5'd14, 0, '0, 0);
      expect_op(1, 0, 0, '0, '0, '0, '0, '0, 1, 2'b01);
      run_op("LHU_103", 1, 0, F3_HU, 32'h103, '0, 5'd15, 0, '0, 0);
      expect_op(0, 0, 0, '0, '0, '0, '0, '0, 1, 2'b01);
      run_op("SW_102", 0, 1, F3_W, 32'h102, 32'h1, 5'd16, 0, '0, 0);

      // Reset while a store request is outstanding: req drops at once.
      @(negedge clk);
      mem_op_valid = 1'b1; MemWrite = 1'b1; Funct3 = F3_W; ALUResult = 32'h300; StoreData = 32'h77;
      @(negedge clk);
      chk("rst_req:req_before", 32'(dmem_req), 32'd1);
      #2 reset = 1'b1;
      #1 chk("rst_req:req_drop", 32'(dmem_req), 32'd0);
      chk("rst_req:we_drop", 32'(dmem_we), 32'd0);
      chk("rst_req:addr_zero", dmem_addr, 32'd0);
      $display("op RST_IN_REQ req=%0d", dmem_req);
      mem_op_valid = 1'b0; MemWrite = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      // Reset while waiting for load data; the late rvalid must be dropped.
      @(negedge clk);
      mem_op_valid = 1'b1; MemRead = 1'b1; Funct3 = F3_W; ALUResult = 32'h400; Rd = 5'd20;
      @(negedge clk);
      chk("rst_wait:req", 32'(dmem_req), 32'd1);
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      chk("rst_wait:in_wait_stall", 32'(stall), 32'd1);
      chk("rst_wait:in_wait_req", 32'(dmem_req), 32'd0);
      #2 reset = 1'b1;
      #1 chk("rst_wait:state_idle", 32'(dut.r_state), 32'(ST_IDLE));
      chk("rst_wait:stall", 32'(stall), 32'd0);
      chk("rst_wait:req_low", 32'(dmem_req), 32'd0);
      mem_op_valid = 1'b0; MemRead = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
      repeat (3) begin
         @(negedge clk);
         chk("rst_wait:no_lv", 32'(load_valid), 32'd0);
         chk("rst_wait:no_req", 32'(dmem_req), 32'd0);
         chk("rst_wait:no_stall", 32'(stall), 32'd0);
      end
      dmem_rvalid = 1'b0;
      $display("op RST_IN_WAIT lv=%0d req=%0d", load_valid, dmem_req);

      chk("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
